packer_flex: RTL
================

// Module: packer_flex
// PURPOSE
//  Parametrised ready/valid width packer. Gathers num_packed_p beats of unpacked_width_p
//  bits into one packed_o word, with selectable lane order and an optional early flush.
//  Sits between narrow pixel/bit streams (e.g. thresholded camera output) and wider
//  byte/word sinks (UART/SPI/FIFO). Full one-beat-per-cycle input throughput.
// PARAMETERS
//  unpacked_width_p  2  bits per input beat (>=1)
//  num_packed_p      4  input beats per output word (>=1)
//  msb_first_p       0  0: lane k at [k*W +: W]; 1: lane k at [(N-1-k)*W +: W]
// PORTS
//  clk_i       in   1                    single clock, rising edge
//  reset_i     in   1                    asynchronous, active-high reset
//  unpacked_i  in   unpacked_width_p     input beat
//  valid_i     in   1                    input beat valid
//  last_i      in   1                    flush: this beat closes the word (PACKER_FLEX_LAST_EN only)
//  ready_o     out  1                    input beat accepted when valid_i && ready_o
//  packed_o    out  W*N                  packed word; unused lanes zero
//  count_o     out  $clog2(N+1)          number of valid lanes in packed_o (1..N)
//  last_o      out  1                    word was closed by last_i
//  valid_o     out  1                    packed word valid
//  ready_i     in   1                    downstream accepts when valid_o && ready_i
// BEHAVIOUR
//  - Reset (async): lane counter 0, accumulator 0, valid_o 0, packed_o 0, count_o 0, last_o 0.
//    Reset mid-word discards partial data; no output produced for it.
//  - in_fire = valid_i && ready_o; out_fire = valid_o && ready_i.
//  - Lane counter cnt in [0, N-1]: on in_fire, unpacked_i is ORed into lane cnt of the accumulator.
//  - Word completes on in_fire when cnt==N-1 (or last_i, if enabled). On completion:
//    the accumulator (including current beat) loads the output register next edge;
//    valid_o=1, count_o=cnt+1, last_o=last_i; accumulator and cnt clear to 0.
//  - Latency: completing beat to valid_o = 1 cycle. Non-completing beats: no output.
//  - Output register is single-entry: holds packed_o/count_o/last_o stable while valid_o && !ready_i.
//    Completion and out_fire in the same cycle: new word loads, valid_o stays 1 (back-to-back).
//    out_fire without completion: valid_o drops to 0 next edge.
//  - ready_o never depends combinationally on valid_i or last_i.
//  - N==1: every beat completes; block is a registered one-entry stage.
//  - Widths: packed_o exactly W*N; count_o sized $clog2(N+1) so count N fits.
// CONFIGURATION
//  PACKER_FLEX_LAST_EN defined:
//   - last_i on in_fire completes the word at any cnt; lanes above cnt zero-filled.
//   - last_i at cnt==N-1: normal completion with last_o=1.
//   - ready_o = !valid_o || ready_i for every lane (any beat may complete a word).
//  PACKER_FLEX_LAST_EN undefined:
//   - last_i ignored; last_o tied 0; count_o always N when valid_o.
//   - ready_o = (cnt != N-1) || !valid_o || ready_i (lanes 0..N-2 accepted while output stalled).
// TESTING
//  1. W=2,N=4,lsb-first: beats 1,2,3,0 with ready_i=1 -> one cycle after 4th beat
//     packed_o=8'h39, count_o=4, valid_o=1 for one cycle.
//  2. Same, msb_first_p=1: beats 1,2,3,0 -> packed_o=8'h6C.
//  3. ready_i=0 after word 8'h39; feed 4 more beats of 2'b11 -> ready_o low at lane 3
//     (without LAST_EN), packed_o held 8'h39; raise ready_i -> next word 8'hFF, no beat lost.
//  4. Continuous valid_i and ready_i for 64 beats -> 16 words, valid_o asserted every 4th cycle,
//     ready_o never low.
//  5. LAST_EN: beats 3,1 with last_i on 2nd -> packed_o=8'h07, count_o=2, last_o=1;
//     next beats start at lane 0.
//  6. Assert reset_i asynchronously after 2 beats -> valid_o/packed_o/count_o=0 immediately;
//     next 4 beats 1,1,1,1 -> packed_o=8'h55 (old partial data absent).

Source files
------------

// File: rtl/packer_flex.sv
// rtl/packer_flex.sv - ready/valid width packer gathering N narrow beats into one wide word
//   Optional early flush via last_i is enabled by defining PACKER_FLEX_LAST_EN.

module packer_flex #(
   parameter int unsigned unpacked_width_p = 2,
   parameter int unsigned num_packed_p     = 4,
   parameter bit          msb_first_p      = 1'b0
) (
   input  logic                                         clk_i,
   input  logic                                         reset_i,
   input  logic [unpacked_width_p-1:0]                  unpacked_i,
   input  logic                                         valid_i,
   input  logic                                         last_i,
   output logic                                         ready_o,
   output logic [unpacked_width_p*num_packed_p-1:0]     packed_o,
   output logic [$clog2(num_packed_p+1)-1:0]            count_o,
   output logic                                         last_o,
   output logic                                         valid_o,
   input  logic                                         ready_i
);

   localparam int W  = unpacked_width_p;
   localparam int N  = num_packed_p;
   localparam int PW = W * N;
   localparam int CW = $clog2(N + 1);
   localparam int LW = (N > 1) ? $clog2(N) : 1;
   localparam logic [LW-1:0] LastLane = LW'(N - 1);

   logic [LW-1:0] cnt_q;
   logic [PW-1:0] acc_q;
   logic [PW-1:0] packed_q;
   logic [CW-1:0] count_q;
   logic          last_q;
   logic          valid_q;

   logic [LW-1:0] lane;
   logic [PW-1:0] beat_vec;
   logic          at_last_lane;
   logic          flush;
   logic          in_fire;
   logic          out_fire;
   logic          word_done;

   assign at_last_lane = (cnt_q == LastLane);

`ifdef PACKER_FLEX_LAST_EN
   // Any beat may close a word, so every beat needs room in the output register.
   assign flush   = last_i;
   assign ready_o = !valid_q || ready_i;
`else
   // Only the final lane writes the output register; earlier lanes keep flowing while stalled.
   logic unused_last;
   assign unused_last = last_i;
   assign flush   = 1'b0;
   assign ready_o = !at_last_lane || !valid_q || ready_i;
`endif

   assign in_fire   = valid_i && ready_o;
   assign out_fire  = valid_q && ready_i;
   assign word_done = in_fire && (at_last_lane || flush);

   // Map the running lane counter onto a physical lane position and place the beat there.
   always_comb begin
      lane     = msb_first_p ? (LastLane - cnt_q) : cnt_q;
      beat_vec = PW'(unpacked_i) << (int'(lane) * W);
   end

   // Accumulate beats, hand finished words to the single-entry output register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         packed_q <= '0;
         count_q  <= '0;
         last_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         if (word_done) begin
            packed_q <= acc_q | beat_vec;
            count_q  <= CW'(cnt_q) + CW'(1);
            last_q   <= flush;
            valid_q  <= 1'b1;
            acc_q    <= '0;
            cnt_q    <= '0;
         end else begin
            if (in_fire) begin
               acc_q <= acc_q | beat_vec;
               cnt_q <= cnt_q + LW'(1);
            end
            if (out_fire) begin
               valid_q <= 1'b0;
            end
         end
      end
   end

   assign packed_o = packed_q;
   assign count_o  = count_q;
   assign last_o   = last_q;
   assign valid_o  = valid_q;

endmodule
